jedro_1_lsu: RTL and testbench

Load-store unit controller for the jedro_1 RV32I core. It accepts one decoded load/store request at a time from the decode/execute stage and sequences the single-port data-memory bus through a req/gnt/rvalid handshake. It generates byte enables and lane-replicated store data, and returns sign- or zero-extended load data with its destination register. Misaligned or illegal-width accesses are trapped before any bus activity.

---
 rtl/jedro_1_lsu.sv | 155 +++++++++++++++
 tb/tb_jedro_1_lsu.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_lsu.sv
// ============================================================================
// jedro_1_lsu : load-store unit controller for the jedro_1 RV32I core
// Revision    : 1.0
// ============================================================================
`default_nettype none

module jedro_1_lsu #(
   parameter int DATA_WIDTH     = 32,
   parameter int LSU_CTRL_WIDTH = 4,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      ctrl_valid_i,
   input  logic [LSU_CTRL_WIDTH-1:0] ctrl_i,
   input  logic [DATA_WIDTH-1:0]     addr_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
   input  logic [REG_ADDR_WIDTH-1:0] regdest_i,
   output logic                      ready_o,
   output logic [DATA_WIDTH-1:0]     rdata_o,
   output logic                      rdata_valid_o,
   output logic [REG_ADDR_WIDTH-1:0] regdest_o,
   output logic                      misaligned_o,
   output logic                      dmem_req_o,
   output logic                      dmem_we_o,
   output logic [3:0]                dmem_be_o,
   output logic [DATA_WIDTH-1:0]     dmem_addr_o,
   output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
   input  logic                      dmem_gnt_i,
   input  logic                      dmem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]     dmem_rdata_i
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t                      r_state;
   state_t                      w_next_state;
   logic [LSU_CTRL_WIDTH-1:0]   r_ctrl;
   logic [DATA_WIDTH-1:0]       r_addr;
   logic [DATA_WIDTH-1:0]       r_wdata;
   logic [REG_ADDR_WIDTH-1:0]   r_regdest;
   logic [DATA_WIDTH-1:0]       r_rdata;
   logic                        r_rdata_valid;

   logic                        w_illegal;
   logic [3:0]                  w_be;
   logic [DATA_WIDTH-1:0]       w_wdata_rep;
   logic [DATA_WIDTH-1:0]       w_shifted;
   logic [DATA_WIDTH-1:0]       w_load_data;

   // Legality is judged on the incoming request so no bus cycle is ever issued for it
   always_comb begin
      w_illegal = 1'b0;
      case (ctrl_i[2:0])
         3'b001, 3'b101: w_illegal = addr_i[0];
         3'b010:         w_illegal = (addr_i[1:0] != 2'b00);
         3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
         default:        w_illegal = 1'b0;
      endcase
      if (ctrl_i[3] && ctrl_i[2])
         w_illegal = 1'b1;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (ctrl_valid_i)
               w_next_state = w_illegal ? S_ERR : S_REQ;
         end
         S_REQ: begin
            if (dmem_gnt_i)
               w_next_state = r_ctrl[3] ? S_IDLE : S_RESP;
         end
         S_RESP: begin
            if (dmem_rvalid_i)
               w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_be = 4'b0000;
      case (r_ctrl[1:0])
         2'b00:   w_be = 4'b0001 << r_addr[1:0];
         2'b01:   w_be = 4'b0011 << {r_addr[1], 1'b0};
         default: w_be = 4'b1111;
      endcase

      w_wdata_rep = r_wdata;
      case (r_ctrl[1:0])
         2'b00:   w_wdata_rep = {4{r_wdata[7:0]}};
         2'b01:   w_wdata_rep = {2{r_wdata[15:0]}};
         default: w_wdata_rep = r_wdata;
      endcase
   end

   // Bring the addressed lane down to bit 0, then extend per funct3
   always_comb begin
      w_shifted   = dmem_rdata_i >> {r_addr[1:0], 3'b000};
      w_load_data = w_shifted;
      case (r_ctrl[2:0])
         3'b000:  w_load_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
         3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b100:  w_load_data = {24'h000000, w_shifted[7:0]};
         3'b101:  w_load_data = {16'h0000,   w_shifted[15:0]};
         default: w_load_data = w_shifted;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= S_IDLE;
         r_ctrl        <= '0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_regdest     <= '0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_rdata_valid <= 1'b0;
         if (r_state == S_IDLE && ctrl_valid_i) begin
            r_ctrl    <= ctrl_i;
            r_addr    <= addr_i;
            r_wdata   <= wdata_i;
            r_regdest <= regdest_i;
         end
         if (r_state == S_RESP && dmem_rvalid_i) begin
            r_rdata       <= w_load_data;
            r_rdata_valid <= 1'b1;
         end
      end
   end

   assign ready_o       = (r_state == S_IDLE);
   assign misaligned_o  = (r_state == S_ERR);
   assign dmem_req_o    = (r_state == S_REQ);
   assign dmem_we_o     = (r_state == S_REQ) && r_ctrl[3];
   assign dmem_be_o     = (r_state == S_REQ) ? w_be : 4'b0000;
   assign dmem_addr_o   = {r_addr[DATA_WIDTH-1:2], 2'b00};
   assign dmem_wdata_o  = w_wdata_rep;
   assign rdata_o       = r_rdata;
   assign rdata_valid_o = r_rdata_valid;
   assign regdest_o     = r_regdest;

endmodule

`default_nettype wire

// File: tb/tb_jedro_1_lsu.sv
// ============================================================================
// tb_jedro_1_lsu : directed self-checking bench for jedro_1_lsu
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_jedro_1_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ctrl_valid = 1'b0;
   logic [3:0]  ctrl = '0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [4:0]  regdest = '0;
   logic        ready;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic [4:0]  regdest_out;
   logic        misaligned;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] maddr;
   logic [31:0] mwdata;
   logic        gnt = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] mrdata = '0;

   int n_checks = 0;
   int n_errors = 0;

   jedro_1_lsu dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .ctrl_valid_i  (ctrl_valid),
      .ctrl_i        (ctrl),
      .addr_i        (addr),
      .wdata_i       (wdata),
      .regdest_i     (regdest),
      .ready_o       (ready),
      .rdata_o       (rdata),
      .rdata_valid_o (rdata_valid),
      .regdest_o     (regdest_out),
      .misaligned_o  (misaligned),
      .dmem_req_o    (req),
      .dmem_we_o     (we),
      .dmem_be_o     (be),
      .dmem_addr_o   (maddr),
      .dmem_wdata_o  (mwdata),
      .dmem_gnt_i    (gnt),
      .dmem_rvalid_i (rvalid),
      .dmem_rdata_i  (mrdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [4:0] rd, input logic [31:0] mem,
                          input int gwait, input int rwait, input logic [31:0] exp);
      ctrl_valid = 1'b1; ctrl = c; addr = a; regdest = rd;
      tick();
      ctrl_valid = 1'b0;
      chk({tag, ".req"}, {31'b0, req}, 32'd1);
      chk({tag, ".we"},  {31'b0, we},  32'd0);
      repeat (gwait) tick();
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      chk({tag, ".req_off"}, {31'b0, req}, 32'd0);
      repeat (rwait - 1) tick();
      rvalid = 1'b1; mrdata = mem;
      tick();
      rvalid = 1'b0;
      chk({tag, ".valid"},   {31'b0, rdata_valid}, 32'd1);
      chk({tag, ".ready"},   {31'b0, ready},       32'd1);
      chk({tag, ".rdata"},   rdata,                exp);
      chk({tag, ".regdest"}, {27'b0, regdest_out}, {27'b0, rd});
      tick();
      chk({tag, ".pulse"},   {31'b0, rdata_valid}, 32'd0);
   endtask

   task automatic err_op(input string tag, input logic [3:0] c, input logic [31:0] a);
      ctrl_valid = 1'b1; ctrl = c; addr = a;
      tick();
      ctrl_valid = 1'b0;
      chk({tag, ".mis"},   {31'b0, misaligned},  32'd1);
      chk({tag, ".req"},   {31'b0, req},         32'd0);
      chk({tag, ".ready"}, {31'b0, ready},       32'd0);
      chk({tag, ".valid"}, {31'b0, rdata_valid}, 32'd0);
      tick();
      chk({tag, ".mis_off"}, {31'b0, misaligned}, 32'd0);
      chk({tag, ".ready2"},  {31'b0, ready},      32'd1);
      chk({tag, ".req2"},    {31'b0, req},        32'd0);
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      chk("rst.ready", {31'b0, ready}, 32'd1);
      chk("rst.req",   {31'b0, req},   32'd0);
      chk("rst.be",    {28'b0, be},    32'd0);
      chk("rst.addr",  maddr,          32'd0);
      chk("rst.rdata", rdata,          32'd0);

      // SB, immediate grant
      ctrl_valid = 1'b1; ctrl = 4'b1000; addr = 32'h0000_1003; wdata = 32'hAABB_CCDD; gnt = 1'b1;
      tick();
      ctrl_valid = 1'b0;
      chk("sb.req",   {31'b0, req},   32'd1);
      chk("sb.we",    {31'b0, we},    32'd1);
      chk("sb.ready", {31'b0, ready}, 32'd0);
      chk("sb.addr",  maddr,          32'h0000_1000);
      chk("sb.be",    {28'b0, be},    32'h8);
      chk("sb.wdata", mwdata,         32'hDDDD_DDDD);
      tick();
      gnt = 1'b0;
      chk("sb.ready2", {31'b0, ready}, 32'd1);
      chk("sb.req2",   {31'b0, req},   32'd0);

      // SH to upper half
      ctrl_valid = 1'b1; ctrl = 4'b1001; addr = 32'h0000_1006; wdata = 32'h0000_BEEF; gnt = 1'b1;
      tick();
      ctrl_valid = 1'b0;
      chk("sh.be",    {28'b0, be}, 32'hC);
      chk("sh.wdata", mwdata,      32'hBEEF_BEEF);
      chk("sh.addr",  maddr,       32'h0000_1004);
      tick();
      gnt = 1'b0;

      // LB stalled grant; lane 1 = 0x80
      ctrl_valid = 1'b1; ctrl = 4'b0000; addr = 32'h0000_2001;
      tick();
      chk("lb.be", {28'b0, be}, 32'h2);
      ctrl_valid = 1'b0;
      tick(); tick();
      chk("lb.stall_req", {31'b0, req}, 32'd1);
      ctrl_valid = 1'b0;
      gnt = 1'b1; tick(); gnt = 1'b0;
      tick();
      rvalid = 1'b1; mrdata = 32'h1234_80FF; regdest = 5'd0;
      tick();
      rvalid = 1'b0;
      chk("lb.valid", {31'b0, rdata_valid}, 32'd1);
      chk("lb.rdata", rdata, 32'hFFFF_FF80);
      tick();
      chk("lb.pulse", {31'b0, rdata_valid}, 32'd0);

      load_op("lb2", 4'b0000, 32'h0000_2001, 5'd7,  32'h1234_80FF, 3, 2, 32'hFFFF_FF80);
      load_op("lhu", 4'b0101, 32'h0000_2002, 5'd9,  32'h8001_0000, 0, 1, 32'h0000_8001);
      load_op("lh",  4'b0001, 32'h0000_2002, 5'd10, 32'h8001_0000, 1, 3, 32'hFFFF_8001);
      load_op("lw",  4'b0010, 32'h0000_2000, 5'd31, 32'h8001_0000, 0, 1, 32'h8001_0000);
      load_op("lbu", 4'b0100, 32'h0000_2003, 5'd4,  32'h8011_2233, 0, 1, 32'h0000_0080);
      load_op("lhp", 4'b0001, 32'h0000_2000, 5'd5,  32'h1234_7FFE, 0, 1, 32'h0000_7FFE);

      err_op("lw_mis", 4'b0010, 32'h0000_3002);
      err_op("sh_mis", 4'b1001, 32'h0000_3001);
      err_op("sbu_ill", 4'b1100, 32'h0000_3000);
      err_op("f3_011", 4'b0011, 32'h0000_3000);

      // Back-to-back: request held valid, second accepted only once idle
      ctrl_valid = 1'b1; ctrl = 4'b0010; addr = 32'h0000_4000; regdest = 5'd3;
      tick();
      ctrl = 4'b1010; addr = 32'h0000_4004; wdata = 32'h1122_3344; regdest = 5'd12;
      chk("b2b.busy", {31'b0, ready}, 32'd0);
      gnt = 1'b1; tick(); gnt = 1'b0;
      chk("b2b.resp_req", {31'b0, req}, 32'd0);
      rvalid = 1'b1; mrdata = 32'hCAFE_BABE;
      tick();
      rvalid = 1'b0;
      chk("b2b.ld_valid", {31'b0, rdata_valid}, 32'd1);
      chk("b2b.ld_rdata", rdata, 32'hCAFE_BABE);
      chk("b2b.ld_rd",    {27'b0, regdest_out}, 32'd3);
      tick();
      ctrl_valid = 1'b0;
      chk("b2b.st_req",   {31'b0, req}, 32'd1);
      chk("b2b.st_we",    {31'b0, we},  32'd1);
      chk("b2b.st_addr",  maddr,        32'h0000_4004);
      chk("b2b.st_be",    {28'b0, be},  32'hF);
      chk("b2b.st_wdata", mwdata,       32'h1122_3344);
      gnt = 1'b1; tick(); gnt = 1'b0;
      chk("b2b.st_done", {31'b0, ready}, 32'd1);

      // Stray rvalid while idle
      rvalid = 1'b1; mrdata = 32'h5555_5555;
      tick();
      rvalid = 1'b0;
      chk("stray.valid", {31'b0, rdata_valid}, 32'd0);
      chk("stray.rdata", rdata, 32'hCAFE_BABE);

      // Reset mid-REQ, then late rvalid must be dropped
      ctrl_valid = 1'b1; ctrl = 4'b0010; addr = 32'h0000_5000; regdest = 5'd8;
      tick();
      ctrl_valid = 1'b0;
      chk("mrst.req_before", {31'b0, req}, 32'd1);
      rst = 1'b1;
      tick();
      chk("mrst.req",   {31'b0, req},   32'd0);
      chk("mrst.ready", {31'b0, ready}, 32'd1);
      tick();
      rst = 1'b0;
      chk("mrst.be",    {28'b0, be},          32'd0);
      chk("mrst.addr",  maddr,                32'd0);
      chk("mrst.wdata", mwdata,               32'd0);
      chk("mrst.rdata", rdata,                32'd0);
      chk("mrst.rd",    {27'b0, regdest_out}, 32'd0);
      chk("mrst.we",    {31'b0, we},          32'd0);
      chk("mrst.mis",   {31'b0, misaligned},  32'd0);
      rvalid = 1'b1; mrdata = 32'h7777_7777;
      tick();
      rvalid = 1'b0;
      chk("mrst.late_rvalid", {31'b0, rdata_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
